// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock gating controller: each channel opens its gated clock on request and
// closes it after a programmable number of idle cycles, using a negedge enable for glitch-free
// gating.
module clk_gate_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_CH-1:0]                req_i,
  input  logic [NUM_CH-1:0]                force_on_i,
  input  logic [CNT_W-1:0]                 idle_limit_i,
  output logic [NUM_CH-1:0]                clk_o,
  output logic [NUM_CH-1:0]                ack_o,
  output logic [$clog2(NUM_CH+1)-1:0]      on_cnt_o,
  output logic                             all_off_o
);

  localparam int unsigned OnCntW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    StOff,
    StOn,
    StIdle
  } state_e;

  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] r_en_n;
  logic [OnCntW-1:0] w_on_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           r_state_q;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_req;

    assign w_req = req_i[g] | force_on_i[g];

    always_comb begin
      w_state_d = r_state_q;
      w_cnt_d   = r_cnt_q;
      case (r_state_q)
        StOff: begin
          if (w_req) w_state_d = StOn;
        end
        StOn: begin
          if (!w_req) begin
            if (idle_limit_i == '0) begin
              w_state_d = StOff;
            end else begin
              w_state_d = StIdle;
              w_cnt_d   = CNT_W'(1);
            end
          end
        end
        StIdle: begin
          // A request arriving in the same cycle the limit is reached keeps the gate open.
          if (w_req) begin
            w_state_d = StOn;
            w_cnt_d   = '0;
          end else if (r_cnt_q >= idle_limit_i) begin
            w_state_d = StOff;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          w_state_d = StOff;
          w_cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state_q <= StOff;
        r_cnt_q   <= '0;
      end else begin
        r_state_q <= w_state_d;
        r_cnt_q   <= w_cnt_d;
      end
    end

    assign w_en[g] = (r_state_q != StOff);
  end

  // Enable moves only while clk_i is low, so the AND gate below cannot glitch.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      r_en_n <= '0;
    end else begin
      r_en_n <= w_en;
    end
  end

  assign clk_o = r_en_n & {NUM_CH{clk_i}};
  assign ack_o = w_en;

  always_comb begin
    w_on_cnt = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      w_on_cnt = w_on_cnt + OnCntW'(w_en[n]);
    end
  end

  assign on_cnt_o  = w_on_cnt;
  assign all_off_o = ~|w_en;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus random traffic, compared
// against an idle-run-length model of each channel.
module tb_clk_gate_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int HALF   = 5;
  localparam int OCW    = $clog2(NUM_CH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NUM_CH-1:0] req_i;
  logic [NUM_CH-1:0] force_on_i;
  logic [CNT_W-1:0]  idle_limit_i;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] ack_o;
  logic [OCW-1:0]    on_cnt_o;
  logic              all_off_o;

  always #HALF clk_i = ~clk_i;

  clk_gate_ctrl #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .force_on_i  (force_on_i),
    .idle_limit_i(idle_limit_i),
    .clk_o       (clk_o),
    .ack_o       (ack_o),
    .on_cnt_o    (on_cnt_o),
    .all_off_o   (all_off_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: a gate is open or closed; while open, count consecutive low-request samples and
  // close once that run exceeds the idle limit by one (run-1 >= L).
  bit                m_open[NUM_CH];
  int                m_run [NUM_CH];
  logic [NUM_CH-1:0] m_en_n = '0;
  bit                clk_chk_ok = 1'b0;

  function automatic logic [NUM_CH-1:0] m_ack();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_open[i];
    return v;
  endfunction

  function automatic int popc(input logic [NUM_CH-1:0] v);
    int c = 0;
    for (int i = 0; i < NUM_CH; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_open[i] = 1'b0;
      m_run[i]  = 0;
    end
  endtask

  task automatic model_posedge();
    if (rst_i) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_i[i] | force_on_i[i]) begin
          m_open[i] = 1'b1;
          m_run[i]  = 0;
        end else if (m_open[i]) begin
          m_run[i]++;
          if (m_run[i] - 1 >= int'(idle_limit_i)) begin
            m_open[i] = 1'b0;
            m_run[i]  = 0;
          end
        end
      end
    end
  endtask

  // One clock cycle: check gated clock high phase, advance model, check registered outputs.
  task automatic tick();
    logic [NUM_CH-1:0] exp;
    @(posedge clk_i);
    #1;
    if (clk_chk_ok) chk("clk_hi", 32'(clk_o), 32'(m_en_n));
    model_posedge();
    @(negedge clk_i);
    #1;
    exp = m_ack();
    chk("ack", 32'(ack_o), 32'(exp));
    chk("on_cnt", 32'(on_cnt_o), 32'(popc(exp)));
    chk("all_off", 32'(all_off_o), 32'(exp == '0));
    chk("clk_lo", 32'(clk_o), 32'h0);
    m_en_n     = rst_i ? '0 : exp;
    clk_chk_ok = 1'b1;
  endtask

  // Pulse-width and edge-count monitor on every gated clock.
  int                rise_cnt[NUM_CH];
  time               rise_t  [NUM_CH];
  logic [NUM_CH-1:0] clk_prev = '0;

  initial for (int i = 0; i < NUM_CH; i++) rise_cnt[i] = 0;

  always @(clk_o) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (clk_o[i] === 1'b1 && clk_prev[i] === 1'b0) begin
        rise_t[i] = $time;
        rise_cnt[i]++;
      end else if (clk_o[i] === 1'b0 && clk_prev[i] === 1'b1) begin
        chk("glitch_w", 32'(($time - rise_t[i]) >= HALF), 32'h1);
      end
    end
    clk_prev = clk_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  int snap;
  int snaps[NUM_CH];
  int d;

  initial begin
    model_reset();
    rst_i        = 1'b1;
    req_i        = 4'hF;
    force_on_i   = '0;
    idle_limit_i = 8'd3;

    // Reset with all requests high, then release.
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    chk("rel_ack", 32'(ack_o), 32'hF);
    tick();

    // Hysteresis L=3 on ch0: four pulses from the drop edge onwards.
    idle_limit_i = 8'd3;
    req_i        = 4'b0001;
    repeat (5) tick();
    req_i = '0;
    snap  = rise_cnt[0];
    repeat (7) tick();
    chk("hyst_pulses", 32'(rise_cnt[0] - snap), 32'd4);

    // L=0 on ch1: single pulse at the drop, quick re-wake.
    idle_limit_i = 8'd0;
    req_i        = 4'b0010;
    repeat (3) tick();
    req_i = '0;
    snap  = rise_cnt[1];
    tick();
    tick();
    chk("l0_pulses", 32'(rise_cnt[1] - snap), 32'd1);
    req_i = 4'b0010;
    tick();
    chk("l0_rewake", 32'(ack_o[1]), 32'h1);
    repeat (2) tick();

    // Re-wake from IDLE without a gap, then a request landing exactly when cnt==L.
    idle_limit_i = 8'd5;
    req_i        = 4'b0001;
    repeat (3) tick();
    req_i = '0;
    repeat (2) tick();
    req_i = 4'b0001;
    repeat (3) tick();
    idle_limit_i = 8'd2;
    req_i        = '0;
    tick();
    tick();
    req_i = 4'b0001;
    tick();
    chk("hit_l_open", 32'(ack_o[0]), 32'h1);
    repeat (2) tick();

    // Force-on keeps ch2 running; then live limit reduction closes it early.
    req_i        = '0;
    idle_limit_i = 8'd0;
    force_on_i   = 4'b0100;
    snap         = rise_cnt[2];
    repeat (20) tick();
    chk("force_pulses", 32'(rise_cnt[2] - snap), 32'd19);
    force_on_i   = '0;
    idle_limit_i = 8'd10;
    repeat (4) tick();
    chk("idle_open", 32'(ack_o[2]), 32'h1);
    idle_limit_i = 8'd2;
    tick();
    chk("live_l_close", 32'(ack_o[2]), 32'h0);
    tick();

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      rst_i = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) == 0) req_i[i] = ~req_i[i];
      end
      force_on_i   = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      idle_limit_i = CNT_W'($urandom_range(0, 6));
      tick();
    end

    // Reset at an arbitrary phase with every channel running.
    rst_i        = 1'b0;
    force_on_i   = '0;
    req_i        = 4'hF;
    idle_limit_i = 8'd3;
    repeat (2) tick();
    d = $urandom_range(0, 8);
    if (d == 4) d = 5;
    #(d);
    for (int i = 0; i < NUM_CH; i++) snaps[i] = rise_cnt[i];
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      chk("rst_edges", 32'((rise_cnt[i] - snaps[i]) <= 1), 32'h1);
    end
    chk("rst_clk", 32'(clk_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_on_cnt", 32'(on_cnt_o), 32'h0);
    chk("rst_all_off", 32'(all_off_o), 32'h1);
    model_reset();
    m_en_n = '0;
    tick();
    rst_i = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
